led_seg_output: RTL and testbench

LED_SEG_OUTPUT -- requirements
Module: led_seg_output

---
 rtl/led_seg_output_pkg.sv | 34 +++
 rtl/led_seg_output_hex_to_seg.sv | 30 +++
 rtl/led_seg_output.sv | 98 +++++++++
 tb/tb_led_seg_output.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/led_seg_output_pkg.sv
// Shared MMIO address map and output-device decode helpers.
// Input-device and output-device register addresses live side by side here.
package led_seg_output_pkg;

    localparam logic [31:0] MMIO_SWITCH_LO_ADDR = 32'hFFFF_FFF1;
    localparam logic [31:0] MMIO_SWITCH_HI_ADDR = 32'hFFFF_FFF3;
    localparam logic [31:0] MMIO_BUTTON_ADDR    = 32'hFFFF_FFF5;

    localparam logic [31:0] MMIO_LED_ADDR       = 32'hFFFF_FFC1;
    localparam logic [31:0] MMIO_SEG_VALUE_ADDR = 32'hFFFF_FFC3;
    localparam logic [31:0] MMIO_SEG_BLANK_ADDR = 32'hFFFF_FFC5;

    localparam int unsigned NUM_DIGITS = 8;
    localparam logic [7:0]  SEG_OFF    = 8'hFF;

    typedef enum logic [1:0] {
        WR_NONE,
        WR_LED,
        WR_SEG,
        WR_BLANK
    } out_sel_t;

    function automatic out_sel_t decode_out(input logic [31:0] addr);
        out_sel_t sel;
        case (addr)
            MMIO_LED_ADDR:       sel = WR_LED;
            MMIO_SEG_VALUE_ADDR: sel = WR_SEG;
            MMIO_SEG_BLANK_ADDR: sel = WR_BLANK;
            default:             sel = WR_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/led_seg_output_hex_to_seg.sv
// Combinational hex nibble to 7-segment decoder, active-low {g,f,e,d,c,b,a}.
module hex_to_seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/led_seg_output.sv
// MMIO LED bank and 8-digit multiplexed 7-segment display driver.
// Digits are scanned one at a time; each is held for SCAN_DIV clk cycles.
module led_seg_output
    import led_seg_output_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ioCtrl,
    input  logic        memWrite,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [15:0] led,
    output logic [7:0]  segEn,
    output logic [7:0]  segOut
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);

    logic [15:0]   ledReg;
    logic [31:0]   segValue;
    logic [7:0]    blankMask;
    logic [PW-1:0] prescaler;
    logic [2:0]    digitIdx;

    out_sel_t      wr_sel;
    logic [3:0]    nibble;
    logic [6:0]    seg7;
    logic [7:0]    seg_en_nxt;
    logic [7:0]    seg_out_nxt;

    always_comb begin
        wr_sel = WR_NONE;
        if (ioCtrl && memWrite) begin
            wr_sel = decode_out(address);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ledReg    <= '0;
            segValue  <= '0;
            blankMask <= '1;
            led       <= '0;
        end else begin
            case (wr_sel)
                WR_LED:   ledReg    <= writeData[15:0];
                WR_SEG:   segValue  <= writeData;
                WR_BLANK: blankMask <= writeData[7:0];
                default:  ;
            endcase
            led <= ledReg;
        end
    end

    // Register writes never touch the scan counters, so a mid-slot update
    // only changes what the active digit shows.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prescaler <= '0;
            digitIdx  <= '0;
        end else if (prescaler == PS_LAST) begin
            prescaler <= '0;
            digitIdx  <= digitIdx + 3'd1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    assign nibble = segValue[{digitIdx, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .hex (nibble),
        .seg (seg7)
    );

    always_comb begin
        seg_en_nxt  = SEG_OFF;
        seg_out_nxt = SEG_OFF;
        if (!blankMask[digitIdx]) begin
            seg_en_nxt  = ~(8'b1 << digitIdx);
            seg_out_nxt = {1'b1, seg7};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            segEn  <= SEG_OFF;
            segOut <= SEG_OFF;
        end else begin
            segEn  <= seg_en_nxt;
            segOut <= seg_out_nxt;
        end
    end

endmodule

// File: tb/tb_led_seg_output.sv
// Directed self-checking bench for led_seg_output with SCAN_DIV=4.
module tb_led_seg_output;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ioCtrl = 1'b0;
    logic        memWrite = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] writeData = '0;
    logic [15:0] led;
    logic [7:0]  segEn;
    logic [7:0]  segOut;

    int n_chk = 0;
    int n_bad = 0;

    led_seg_output #(.SCAN_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ioCtrl    (ioCtrl),
        .memWrite  (memWrite),
        .address   (address),
        .writeData (writeData),
        .led       (led),
        .segEn     (segEn),
        .segOut    (segOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d);
        ioCtrl    = 1'b1;
        memWrite  = 1'b1;
        address   = a;
        writeData = d;
    endtask

    task automatic idle();
        ioCtrl    = 1'b0;
        memWrite  = 1'b0;
        address   = '0;
        writeData = '0;
    endtask

    // Leaves the bench at a negedge with rst still low.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        check("rst_led", 32'(led), 32'h0);
        check("rst_en", 32'(segEn), 32'hFF);
        check("rst_out", 32'(segOut), 32'hFF);
    endtask

    // segs holds the expected segOut for digit d at bits [8d+7:8d].
    task automatic scan_test(input string name, input logic [31:0] val,
                             input logic [7:0] mask, input logic [63:0] segs);
        int d;
        logic [7:0] e_en;
        logic [7:0] e_out;
        do_reset();
        rst = 1'b1;
        drive(32'hFFFF_FFC3, val);
        @(negedge clk);
        drive(32'hFFFF_FFC5, {24'h0, mask});
        check({name, "_k0_en"}, 32'(segEn), 32'hFF);
        @(negedge clk);
        idle();
        check({name, "_k1_en"}, 32'(segEn), 32'hFF);
        for (int k = 2; k < 36; k++) begin
            @(negedge clk);
            d = (k / 4) % 8;
            if (mask[d]) begin
                e_en  = 8'hFF;
                e_out = 8'hFF;
            end else begin
                e_en  = ~(8'(1) << d);
                e_out = segs[d*8 +: 8];
            end
            check($sformatf("%s_k%0d_en", name, k), 32'(segEn), 32'(e_en));
            check($sformatf("%s_k%0d_out", name, k), 32'(segOut), 32'(e_out));
        end
    endtask

    initial begin
        // Reset state held while everything is blanked
        do_reset();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_led", 32'(led), 32'h0);
            check("idle_en", 32'(segEn), 32'hFF);
            check("idle_out", 32'(segOut), 32'hFF);
        end

        // LED write latency and address/strobe filtering
        drive(32'hFFFF_FFC1, 32'h0000_A5A5);
        @(negedge clk);
        idle();
        check("led_lat0", 32'(led), 32'h0);
        @(negedge clk);
        check("led_lat1", 32'(led), 32'hA5A5);
        drive(32'hFFFF_FFC9, 32'h0000_1234);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("led_badaddr", 32'(led), 32'hA5A5);
        drive(32'hFFFF_FFC1, 32'h0000_FFFF);
        memWrite = 1'b0;
        @(negedge clk);
        idle();
        @(negedge clk);
        check("led_nomw", 32'(led), 32'hA5A5);
        drive(32'hFFFF_FFC1, 32'h0000_FFFF);
        ioCtrl = 1'b0;
        @(negedge clk);
        idle();
        @(negedge clk);
        check("led_noio", 32'(led), 32'hA5A5);
        check("led_en_blank", 32'(segEn), 32'hFF);

        // Back-to-back writes, last one wins
        drive(32'hFFFF_FFC1, 32'hDEAD_1111);
        @(negedge clk);
        drive(32'hFFFF_FFC1, 32'hBEEF_2222);
        @(negedge clk);
        idle();
        check("b2b_first", 32'(led), 32'h1111);
        @(negedge clk);
        check("b2b_last", 32'(led), 32'h2222);

        // Full scans: digits 0..7, all sixteen hex patterns, then blanking
        scan_test("scan0", 32'h0123_4567, 8'h00, 64'hC0F9_A4B0_9992_82F8);
        scan_test("scan1", 32'h89AB_CDEF, 8'h00, 64'h8090_8883_C6A1_868E);
        scan_test("blank", 32'hFFFF_FFFF, 8'hF0, 64'h8E8E_8E8E_8E8E_8E8E);

        // Mid-slot segValue update on digit 0
        do_reset();
        rst = 1'b1;
        drive(32'hFFFF_FFC5, 32'hABCD_EF00);
        @(negedge clk);
        idle();
        check("mid_k0_en", 32'(segEn), 32'hFF);
        check("mid_k0_out", 32'(segOut), 32'hFF);
        @(negedge clk);
        check("mid_k1_en", 32'(segEn), 32'hFE);
        check("mid_k1_out", 32'(segOut), 32'hC0);
        drive(32'hFFFF_FFC3, 32'h0000_000E);
        @(negedge clk);
        idle();
        check("mid_k2_en", 32'(segEn), 32'hFE);
        check("mid_k2_out", 32'(segOut), 32'hC0);
        @(negedge clk);
        check("mid_k3_en", 32'(segEn), 32'hFE);
        check("mid_k3_out", 32'(segOut), 32'h86);
        for (int k = 4; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("mid_k%0d_en", k), 32'(segEn), 32'hFD);
            check($sformatf("mid_k%0d_out", k), 32'(segOut), 32'hC0);
        end
        @(negedge clk);
        check("mid_k8_en", 32'(segEn), 32'hFB);

        // Reset colliding with an LED write mid-scan
        drive(32'hFFFF_FFC1, 32'h0000_7777);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("pre_rst_led", 32'(led), 32'h7777);
        drive(32'hFFFF_FFC1, 32'h0000_BEEF);
        rst = 1'b0;
        @(negedge clk);
        check("coll_led", 32'(led), 32'h0);
        check("coll_en", 32'(segEn), 32'hFF);
        check("coll_out", 32'(segOut), 32'hFF);
        rst = 1'b1;
        drive(32'hFFFF_FFC5, 32'h0000_0000);
        @(negedge clk);
        idle();
        check("coll_k0_led", 32'(led), 32'h0);
        check("coll_k0_en", 32'(segEn), 32'hFF);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("coll_k%0d_led", k), 32'(led), 32'h0);
            check($sformatf("coll_k%0d_en", k), 32'(segEn), 32'hFE);
            check($sformatf("coll_k%0d_out", k), 32'(segOut), 32'hC0);
        end
        @(negedge clk);
        check("coll_k4_en", 32'(segEn), 32'hFD);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
